// File: rtl/i2c_cfg_sequencer_pkg.sv
// i2c_pkg: shared definitions for the I2C configuration sequencer.
//   - FSM state encodings (legacy numeric values) and the matching state enum
//   - master write-enable constant (the sequencer only ever writes)
//   - ROM entry field layout: {slave_addr, payload}, payload in the low bits
package i2c_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_FETCH       = 3'd1;
  localparam logic [2:0] ST_LOAD        = 3'd2;
  localparam logic [2:0] ST_ISSUE       = 3'd3;
  localparam logic [2:0] ST_WAIT_ACCEPT = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE   = 3'd5;
  localparam logic [2:0] ST_GAP         = 3'd6;
  localparam logic [2:0] ST_FINISH      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE        = ST_IDLE,
    S_FETCH       = ST_FETCH,
    S_LOAD        = ST_LOAD,
    S_ISSUE       = ST_ISSUE,
    S_WAIT_ACCEPT = ST_WAIT_ACCEPT,
    S_WAIT_DONE   = ST_WAIT_DONE,
    S_GAP         = ST_GAP,
    S_FINISH      = ST_FINISH
  } seq_state_e;

  localparam logic I2C_WEN = 1'b1;

  // Payload occupies rom_data[DATA_W-1:0]; slave address sits directly above it.
  localparam int unsigned ENTRY_DATA_LSB = 0;

  function automatic int unsigned entry_addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// i2c_cfg_sequencer_if: write-request bus between the configuration sequencer
// and the I2C master.
//   m_req        request pulse (sequencer -> master)
//   m_wen        write enable, always 1
//   m_slave_addr slave address for the transfer
//   m_writedata  payload for the transfer
//   m_ready      master idle (master -> sequencer)
//   m_addr_err   address NACK pulse
//   m_noack_err  data NACK pulse
// Modports: master = sequencer side (drives the request), slave = I2C master side.
interface i2c_cfg_sequencer_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
);
  logic              m_req;
  logic              m_wen;
  logic [ADDR_W-1:0] m_slave_addr;
  logic [DATA_W-1:0] m_writedata;
  logic              m_ready;
  logic              m_addr_err;
  logic              m_noack_err;

  modport master (
    output m_req, m_wen, m_slave_addr, m_writedata,
    input  m_ready, m_addr_err, m_noack_err
  );

  modport slave (
    input  m_req, m_wen, m_slave_addr, m_writedata,
    output m_ready, m_addr_err, m_noack_err
  );
endinterface

// File: rtl/i2c_seq_gap_timer.sv
// i2c_seq_gap_timer: loadable down-counter with a done flag.
//   clk, rst    clock, synchronous active-high reset
//   i_load      load i_load_val this cycle
//   i_load_val  start value; o_done rises i_load_val cycles after the load
//   o_done      high while the count is zero
module i2c_seq_gap_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a ROM table of I2C writes, issuing one at a time to
// the I2C master with per-entry NACK retry and a fixed idle gap between
// transfers.
//   clk, rst    clock, synchronous active-high reset
//   start       pulse, begins a run from entry 0 (ignored unless idle)
//   busy        high from accepted start until done/fail
//   done        1-cycle pulse when every entry was acked
//   fail        sticky; an entry exhausted its retries
//   fail_index  index of the failing entry
//   rom_addr    table read address; rom_data valid one cycle later
//   rom_data    {slave_addr, payload}
//   m_bus       write-request bus to the I2C master (master modport)
// Optional build macro I2C_SEQ_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES) on
// WAIT_ACCEPT/WAIT_DONE and a sticky timeout output.
module i2c_cfg_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_ENTRY  = 16,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 100,
`ifdef I2C_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 65535,
`endif
  localparam int unsigned IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [IDX_W-1:0]         fail_index,
  output logic [IDX_W-1:0]         rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] rom_data,
`ifdef I2C_SEQ_TIMEOUT_EN
  output logic                     timeout,
`endif
  i2c_cfg_sequencer_if.master      m_bus
);

  localparam int unsigned RET_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ADDR_LSB = entry_addr_lsb(DATA_W);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRY - 1);
  localparam logic [RET_W-1:0] RETRY_LIM = RET_W'(MAX_RETRY);
  // Loaded on the WAIT_DONE->GAP edge so GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [IDX_W-1:0]  r_fail_index;
  logic [IDX_W-1:0]  r_index;
  logic [RET_W-1:0]  r_retry;
  logic              r_err;
  logic              r_req;
  logic [ADDR_W-1:0] r_slave_addr;
  logic [DATA_W-1:0] r_writedata;

  logic w_gap_load;
  logic w_gap_done;
  logic w_last;
  logic w_can_retry;

  assign w_last      = (r_index == LAST_IDX);
  assign w_can_retry = (r_retry < RETRY_LIM);
  assign w_gap_load  = (r_state == S_WAIT_DONE) && m_bus.m_ready;

  i2c_seq_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .o_done     (w_gap_done)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned         TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]     TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  logic r_timeout;
  logic w_wd_load;
  logic w_wd_done;
  logic w_wd_hit;

  // Reloaded on entry to each wait state, so it restarts when WAIT_ACCEPT exits.
  assign w_wd_load = ((r_state == S_ISSUE) && m_bus.m_ready) ||
                     ((r_state == S_WAIT_ACCEPT) && !m_bus.m_ready);

  i2c_seq_gap_timer #(.W(TO_W)) u_wd_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_wd_load),
    .i_load_val (TO_LOAD),
    .o_done     (w_wd_done)
  );

  assign timeout = r_timeout;
`endif

  always_comb begin
    w_state_nxt = r_state;
`ifdef I2C_SEQ_TIMEOUT_EN
    w_wd_hit = 1'b0;
`endif
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_ISSUE;
      S_ISSUE:  if (m_bus.m_ready) w_state_nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (!m_bus.m_ready) begin
          w_state_nxt = S_WAIT_DONE;
`ifdef I2C_SEQ_TIMEOUT_EN
        end else if (w_wd_done) begin
          w_state_nxt = S_FINISH;
          w_wd_hit    = 1'b1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (m_bus.m_ready) begin
          w_state_nxt = S_GAP;
`ifdef I2C_SEQ_TIMEOUT_EN
        end else if (w_wd_done) begin
          w_state_nxt = S_FINISH;
          w_wd_hit    = 1'b1;
`endif
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          if (!r_err)          w_state_nxt = w_last ? S_FINISH : S_FETCH;
          else if (w_can_retry) w_state_nxt = S_ISSUE;
          else                  w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_index <= '0;
      r_index      <= '0;
      r_retry      <= '0;
      r_err        <= 1'b0;
      r_req        <= 1'b0;
      r_slave_addr <= '0;
      r_writedata  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (r_state == S_ISSUE) && m_bus.m_ready;
      r_done  <= 1'b0;

      if ((w_state_nxt == S_ISSUE) && (r_state != S_ISSUE)) begin
        r_err <= 1'b0;
      end else if (r_state == S_WAIT_DONE) begin
        r_err <= r_err | m_bus.m_addr_err | m_bus.m_noack_err;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_index <= '0;
            r_retry <= '0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          r_slave_addr <= rom_data[ADDR_LSB +: ADDR_W];
          r_writedata  <= rom_data[ENTRY_DATA_LSB +: DATA_W];
        end
        S_GAP: begin
          if (w_gap_done) begin
            if (!r_err) begin
              if (w_last) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
              end else begin
                r_index <= r_index + IDX_W'(1);
                r_retry <= '0;
              end
            end else if (w_can_retry) begin
              r_retry <= r_retry + RET_W'(1);
            end else begin
              r_fail       <= 1'b1;
              r_fail_index <= r_index;
              r_busy       <= 1'b0;
            end
          end
        end
        default: ;
      endcase

`ifdef I2C_SEQ_TIMEOUT_EN
      if (w_wd_hit) begin
        r_fail       <= 1'b1;
        r_fail_index <= r_index;
        r_timeout    <= 1'b1;
        r_busy       <= 1'b0;
      end
`endif
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign fail       = r_fail;
  assign fail_index = r_fail_index;
  assign rom_addr   = r_index;

  assign m_bus.m_req        = r_req;
  assign m_bus.m_wen        = I2C_WEN;
  assign m_bus.m_slave_addr = r_slave_addr;
  assign m_bus.m_writedata  = r_writedata;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Testbench for i2c_cfg_sequencer: 3-entry table, behavioural I2C master with
// configurable NACK injection, table-driven run scenarios plus hand-written
// sequences for ready stall, busy-start, mid-run reset and (with
// I2C_SEQ_TIMEOUT_EN) the watchdog.
module tb_i2c_cfg_sequencer;

  localparam int BUSY_CYC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, fail;
  logic [1:0]  fail_index, rom_addr;
  logic [22:0] rom_q;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic        timeout;
`endif

  logic ready_q = 1'b1;
  logic hold_low = 1'b0;
  logic err_a = 1'b0;
  logic err_n = 1'b0;

  i2c_cfg_sequencer_if #(.ADDR_W(7), .DATA_W(16)) m_bus ();

  assign m_bus.m_ready     = ready_q & ~hold_low;
  assign m_bus.m_addr_err  = err_a;
  assign m_bus.m_noack_err = err_n;

  i2c_cfg_sequencer #(
    .NUM_ENTRY      (3),
    .ADDR_W         (7),
    .DATA_W         (16),
    .MAX_RETRY      (3),
`ifdef I2C_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES (50),
`endif
    .GAP_CYCLES     (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_index (fail_index),
    .rom_addr   (rom_addr),
    .rom_data   (rom_q),
`ifdef I2C_SEQ_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .m_bus      (m_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [22:0] rom [4];
  initial begin
    rom[0] = {7'h1A, 16'h1E00};
    rom[1] = {7'h1A, 16'h0C00};
    rom[2] = {7'h34, 16'h0097};
    rom[3] = '0;
  end
  always @(posedge clk) rom_q <= rom[rom_addr];

  // Master model configuration and logs
  int err_entry = -1;
  int err_kind  = 0;    // 0 none, 1 data NACK, 2 addr NACK, 3 stray pulse in GAP
  int err_count = 0;    // number of first attempts that fail
  bit stuck     = 1'b0;
  int att [3];
  logic [6:0]  req_addr [$];
  logic [15:0] req_data [$];
  int          req_cyc  [$];
  int          comp_cyc [$];
  int n_double = 0, n_done = 0, n_done_busy = 0;
  logic prev_req = 1'b0;
  int ms = 0, mcnt = 0, ent = 0;
  bit fail_this = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      ms = 0; ready_q = 1'b1; err_a = 1'b0; err_n = 1'b0; prev_req = 1'b0;
    end else begin
      if (m_bus.m_req) begin
        req_addr.push_back(m_bus.m_slave_addr);
        req_data.push_back(m_bus.m_writedata);
        req_cyc.push_back(cyc);
        if (prev_req) n_double++;
      end
      prev_req = m_bus.m_req;
      if (done) begin
        n_done++;
        if (busy) n_done_busy++;
      end
      case (ms)
        0: if (m_bus.m_req) begin
          ent = 0;
          for (int i = 0; i < 3; i++) if (m_bus.m_writedata == rom[i][15:0]) ent = i;
          att[ent]++;
          fail_this = (err_kind != 0) && (ent == err_entry) && (att[ent] <= err_count);
          ready_q = 1'b0; mcnt = BUSY_CYC; ms = 1;
        end
        1: begin
          mcnt--;
          if (mcnt == 0) begin
            if (stuck) ms = 4;
            else if (fail_this && (err_kind == 1 || err_kind == 2)) begin
              if (err_kind == 1) err_n = 1'b1; else err_a = 1'b1;
              ms = 2;
            end else begin
              ready_q = 1'b1; comp_cyc.push_back(cyc);
              ms = (fail_this && err_kind == 3) ? 3 : 0;
            end
          end
        end
        2: begin err_a = 1'b0; err_n = 1'b0; ready_q = 1'b1; comp_cyc.push_back(cyc); ms = 0; end
        3: begin err_n = 1'b1; ms = 5; end
        5: begin err_n = 1'b0; ms = 0; end
        4: if (!stuck) begin ready_q = 1'b1; ms = 0; end
        default: ms = 0;
      endcase
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int st_cyc;

  task automatic start_run();
    req_addr.delete(); req_data.delete(); req_cyc.delete(); comp_cyc.delete();
    for (int i = 0; i < 3; i++) att[i] = 0;
    n_double = 0; n_done = 0; n_done_busy = 0;
    @(negedge clk);
    start = 1'b1; st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_fail_clr", fail, 0);
    check("fetch_rom_addr", rom_addr, 0);
  endtask

  task automatic wait_idle(output int fall_cyc);
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("run_completes", busy, 0);
    fall_cyc = cyc;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          err_entry;
    int          err_kind;
    int          err_count;
    int          n_req;
    logic [15:0] seq;       // expected entry index per request, 2 bits each, LSB first
    bit          exp_done;
    bit          exp_fail;
    int          exp_fidx;
  } case_t;

  case_t cases [6];

  task automatic run_case(input int ci);
    case_t c;
    int    idx, fc;
    c = cases[ci];
    err_entry = c.err_entry; err_kind = c.err_kind; err_count = c.err_count;
    start_run();
    wait_idle(fc);
    check("req_count", req_addr.size(), c.n_req);
    for (int k = 0; k < c.n_req && k < req_addr.size(); k++) begin
      idx = int'(c.seq[k*2 +: 2]);
      check("req_addr", req_addr[k], rom[idx][22:16]);
      check("req_data", req_data[k], rom[idx][15:0]);
    end
    check("done_count", n_done, c.exp_done ? 1 : 0);
    check("done_while_busy", n_done_busy, 0);
    check("fail", fail, c.exp_fail);
    if (c.exp_fail) check("fail_index", fail_index, c.exp_fidx);
    check("single_cycle_req", n_double, 0);
    if (req_cyc.size() > 0) check("start_to_req", req_cyc[0] - st_cyc, 4);
    if (ci == 0 && req_cyc.size() > 1 && comp_cyc.size() > 0)
      check("gap_next_entry", req_cyc[1] - comp_cyc[0], 104);
    if (ci == 1 && req_cyc.size() > 2 && comp_cyc.size() > 1)
      check("gap_retry", req_cyc[2] - comp_cyc[1], 102);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int fc, rel_cyc;
    cases[0] = '{-1, 0, 0,  3, 16'h0024, 1'b1, 1'b0, 0};  // all acked: 0,1,2
    cases[1] = '{ 1, 1, 1,  4, 16'h0094, 1'b1, 1'b0, 0};  // 0,1,1,2
    cases[2] = '{ 2, 2, 99, 6, 16'h0AA4, 1'b0, 1'b1, 2};  // 0,1,2,2,2,2 then fail
    cases[3] = '{ 0, 3, 99, 3, 16'h0024, 1'b1, 1'b0, 0};  // stray NACK in GAP ignored
    cases[4] = '{ 0, 1, 2,  5, 16'h0240, 1'b1, 1'b0, 0};  // 0,0,0,1,2
    cases[5] = '{ 1, 1, 3,  6, 16'h0954, 1'b1, 1'b0, 0};  // last retry succeeds

    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_fail_index", fail_index, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_m_req", m_bus.m_req, 0);
    check("rst_m_slave_addr", m_bus.m_slave_addr, 0);
    check("rst_m_writedata", m_bus.m_writedata, 0);
    check("m_wen", m_bus.m_wen, 1);
    rst = 1'b0;
    @(negedge clk);

    for (int ci = 0; ci < 6; ci++) run_case(ci);

    // Ready held low: request waits for ready, and start while busy is ignored
    err_kind = 0; err_entry = -1;
    hold_low = 1'b1;
    start_run();
    repeat (19) @(negedge clk);
    check("no_req_while_not_ready", req_addr.size(), 0);
    hold_low = 1'b0; rel_cyc = cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(fc);
    if (req_cyc.size() > 0) check("req_after_ready", req_cyc[0] - rel_cyc, 1);
    check("stall_req_count", req_addr.size(), 3);
    for (int k = 0; k < 3 && k < req_data.size(); k++)
      check("stall_req_data", req_data[k], rom[k][15:0]);
    check("stall_single_req", n_double, 0);
    check("stall_done", n_done, 1);

    // Reset during WAIT_DONE of entry 1
    start_run();
    for (int i = 0; i < 2000 && req_addr.size() < 2; i++) @(negedge clk);
    check("reached_entry1", req_addr.size(), 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_fail", fail, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_m_req", m_bus.m_req, 0);
    check("midrst_m_slave_addr", m_bus.m_slave_addr, 0);
    check("midrst_m_writedata", m_bus.m_writedata, 0);
    rst = 1'b0;
    start_run();
    wait_idle(fc);
    check("post_rst_req_count", req_addr.size(), 3);
    if (req_data.size() > 0) check("post_rst_first_data", req_data[0], rom[0][15:0]);
    check("post_rst_done", n_done, 1);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never returns ready: watchdog ends the run without retry
    stuck = 1'b1;
    start_run();
    wait_idle(fc);
    check("to_timeout", timeout, 1);
    check("to_fail", fail, 1);
    check("to_fail_index", fail_index, 0);
    check("to_req_count", req_addr.size(), 1);
    check("to_no_done", n_done, 0);
    if (req_cyc.size() > 0) check("to_busy_fall", fc - req_cyc[0], 51);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
Walks a table of I2C write commands and issues them one at a time to the I2C master (req/wen/slave_addr/writedata/ready/error interface), e.g. codec or sensor power-up configuration. Table entries are read from an external synchronous ROM with 1-cycle read latency. The block handles per-entry retry on slave NACK, inter-transaction gap timing, and completion/fail status toward the system.

Parameters:
NUM_ENTRY, 16, number of table entries executed per run (≥1)
ADDR_W, 7, I2C slave address width (master BYTE_SIZE-1)
DATA_W, 16, payload width per entry (master NUM_BYTE*BYTE_SIZE)
MAX_RETRY, 3, retries per entry after the first attempt (0 = no retry)
GAP_CYCLES, 100, idle clk cycles between master completion and next req (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a run from entry 0; ignored while busy
busy  out  1  high from accepted start until done/fail
done  out  1  1-cycle pulse, all entries acked
fail  out  1  sticky; set when an entry exhausts retries; cleared by next accepted start
fail_index  out  $clog2(NUM_ENTRY)  entry index that failed; valid while fail=1
rom_addr  out  $clog2(NUM_ENTRY)  table read address
rom_data  in  ADDR_W+DATA_W  {slave_addr, payload}, valid 1 cycle after rom_addr
m_req  out  1  request pulse to master
m_wen  out  1  constant 1 (write only)
m_slave_addr  out  ADDR_W  registered slave address
m_writedata  out  DATA_W  registered payload
m_ready  in  1  master idle
m_addr_err  in  1  master pulse: address NACK
m_noack_err  in  1  master pulse: data NACK

Behaviour:
- Reset: state IDLE; busy=0, done=0, fail=0, fail_index=0, rom_addr=0, m_req=0, m_slave_addr=0, m_writedata=0; index and retry counters 0.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, FINISH.
- IDLE: start -> FETCH; index=0, retry=0, fail cleared, busy=1 next cycle.
- FETCH: rom_addr=index; one cycle -> LOAD.
- LOAD: capture rom_data into m_slave_addr/m_writedata; -> ISSUE.
- ISSUE: when m_ready=1, assert m_req for exactly one cycle -> WAIT_ACCEPT; if m_ready=0, hold without asserting m_req.
- WAIT_ACCEPT: wait for m_ready=0 (normally the next cycle) -> WAIT_DONE. m_req stays 0.
- WAIT_DONE: OR m_addr_err|m_noack_err into an err flag cleared on entering ISSUE. On m_ready=1 -> GAP.
- GAP: count GAP_CYCLES, then:
  - If err=0 and index==NUM_ENTRY-1 -> FINISH (done pulse).
  - If err=0 otherwise: index+1, retry=0 -> FETCH.
  - If err=1 and retry<MAX_RETRY: retry+1 -> LOAD path re-issues the same registered entry (go directly to ISSUE).
  - If err=1 and retry==MAX_RETRY: fail=1, fail_index=index -> FINISH without done.
- FINISH: busy=0; -> IDLE. done asserts the same cycle busy drops.
- Latency, 0-gap-free path: start to first m_req = 4 cycles (FETCH, LOAD, ISSUE with ready high).
- Error pulses arriving outside WAIT_DONE are ignored.
- start while busy: ignored. start in the same cycle as FINISH: ignored; must be reissued from IDLE.
- Reset mid-run: immediate return to reset values. The master is reset by the same rst, so there is no orphaned transaction.
- Counters: retry width $clog2(MAX_RETRY+1); gap counter width $clog2(GAP_CYCLES+1); index never wraps past NUM_ENTRY-1.

Optional Feature:
I2C_SEQ_TIMEOUT_EN
- With the macro defined: a watchdog counter (parameter TIMEOUT_CYCLES, default 65535) runs in WAIT_ACCEPT and WAIT_DONE and clears on state exit. Expiry sets fail=1, fail_index=index, and goes to FINISH with no retry. An extra output, timeout (sticky, cleared on start), is added.
- Without the macro: no watchdog and no timeout port; the block waits indefinitely on the master.

Decomposition:
- Shared package i2c_pkg: FSM state enum, the master write-enable constant (1), and the ROM entry field layout (ADDR_W/DATA_W slice positions).
- One natural sub-module: i2c_seq_gap_timer, a loadable down-counter with a done flag, reused for GAP and the optional watchdog.

Test Plan:
- NUM_ENTRY=3, table {0x1A,0x1E00},{0x1A,0x0C00},{0x34,0x0097}, all acked, start -> exactly 3 m_req pulses with matching addr/data in order; done pulse once; busy low after; fail=0.
- Entry 1 gets m_noack_err on attempt 1 only -> 4 total m_req, the 3rd repeating entry 1 data 0x0C00; done=1, fail=0.
- Entry 2 gets m_addr_err on every attempt, MAX_RETRY=3 -> entry 2 issued 4 times; fail=1, fail_index=2, no done; next start clears fail.
- Model m_ready held low 20 cycles before ISSUE -> m_req delayed until m_ready=1 and is a single-cycle pulse; gap between completion and next req is exactly GAP_CYCLES=100 (+fixed FSM overhead).
- Assert rst during WAIT_DONE of entry 1 -> next cycle all outputs at reset values; a subsequent start restarts from rom_addr=0.
- With I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, master ready stuck low -> timeout=1, fail=1 at cycle 50 of WAIT_DONE, busy drops.
